// File: rtl/rrot_8_pipe.sv
// Pipelined right rotator: SEL_W registered stages, stage k rotates by 2^k; RROT_SHIFT_MODE_EN adds rrmode (1 = logical right shift).
// Latency SEL_W cycles; a stage loads when empty or when its successor loads, so bubbles collapse and in_ready drops only when full.
module rrot_8_pipe #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rrdata,
  input  logic [SEL_W-1:0] rrsel,
`ifdef RROT_SHIFT_MODE_EN
  input  logic             rrmode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] rrout,
  output logic             out_valid,
  input  logic             out_ready
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("rrot_8_pipe: WIDTH must be a power of two >= 2");
  end
  if (SEL_W != $clog2(WIDTH)) begin : g_bad_sel
    $error("rrot_8_pipe: SEL_W must equal log2(WIDTH)");
  end

  // Index k is the input side of stage k; index SEL_W is the output of the last stage.
  logic [WIDTH-1:0] w_dat [SEL_W+1];
  logic [SEL_W-1:0] w_sel [SEL_W];
  logic [SEL_W:0]   w_vld;
  logic [SEL_W:0]   w_rdy;
`ifdef RROT_SHIFT_MODE_EN
  logic [SEL_W-1:0] w_mode;
  assign w_mode[0] = rrmode;
`endif

  assign w_dat[0]  = rrdata;
  assign w_sel[0]  = rrsel;
  assign w_vld[0]  = in_valid;
  assign in_ready  = w_rdy[0];
  assign rrout     = w_dat[SEL_W];
  assign out_valid = w_vld[SEL_W];

  always_comb begin
    w_rdy        = '0;
    w_rdy[SEL_W] = out_ready;
    for (int k = SEL_W - 1; k >= 0; k--) begin
      w_rdy[k] = !w_vld[k+1] || w_rdy[k+1];
    end
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] r_dat;
    logic             r_vld;
    logic             w_zero;
    logic [WIDTH-1:0] w_step;

`ifdef RROT_SHIFT_MODE_EN
    assign w_zero = w_mode[k];
`else
    assign w_zero = 1'b0;
`endif
    assign w_step = w_zero ? (w_dat[k] >> SH)
                           : ((w_dat[k] >> SH) | (w_dat[k] << (WIDTH - SH)));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_dat <= '0;
      end else if (w_rdy[k]) begin
        r_vld <= w_vld[k];
        r_dat <= w_sel[k][0] ? w_step : w_dat[k];
      end
    end

    assign w_dat[k+1] = r_dat;
    assign w_vld[k+1] = r_vld;

    // Select bits still needed downstream shift down so each stage consumes bit 0.
    if (k < SEL_W - 1) begin : g_carry
      logic [SEL_W-1:0] r_sel;
`ifdef RROT_SHIFT_MODE_EN
      logic             r_mode;
`endif
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_sel  <= '0;
`ifdef RROT_SHIFT_MODE_EN
          r_mode <= 1'b0;
`endif
        end else if (w_rdy[k]) begin
          r_sel  <= w_sel[k] >> 1;
`ifdef RROT_SHIFT_MODE_EN
          r_mode <= w_mode[k];
`endif
        end
      end
      assign w_sel[k+1] = r_sel;
`ifdef RROT_SHIFT_MODE_EN
      assign w_mode[k+1] = r_mode;
`endif
    end
  end

endmodule

// File: tb/tb_rrot_8_pipe.sv
// Directed and randomized checks of the pipelined right rotator: reset, latency, streaming, backpressure, mid-stream reset.
`timescale 1ns/1ps
module tb_rrot_8_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rrdata = 8'h00;
  logic [2:0] rrsel = 3'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rrout;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef RROT_SHIFT_MODE_EN
  logic       rrmode = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rrot_8_pipe #(.WIDTH(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rrdata    (rrdata),
    .rrsel     (rrsel),
`ifdef RROT_SHIFT_MODE_EN
    .rrmode    (rrmode),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rrout     (rrout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] t;
    t = {d, d} >> s;
    return t[7:0];
  endfunction

  task automatic test_reset();
    int seen = 0;
    rst_n = 1'b0; in_valid = 1'b1; rrdata = 8'hFF; rrsel = 3'd1; out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (rrout !== 8'h00) begin n_fail++; $display("FAIL reset_rrout: got %h want 00", rrout); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL reset_nothing_out: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_single(input logic [7:0] d, input logic [2:0] s, input logic m,
                             input logic [7:0] exp, input string name);
    int lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rrdata = d; rrsel = s; in_valid = 1'b1;
`ifdef RROT_SHIFT_MODE_EN
    rrmode = m;
`endif
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; rrdata = ~d; rrsel = ~s;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat != 3) begin n_fail++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
    n_cmp++;
    if (rrout !== exp) begin n_fail++; $display("FAIL %s_data: got %h want %h (mode %0d)", name, rrout, exp, m); end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_no_dup: got out_valid %b want 0", name, out_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] words [256];
    logic [7:0] q [$];
    logic [7:0] exp;
    int sent = 0, recv = 0, cyc = 0, first = -1, last = -1, stalls = 0;
    for (int i = 0; i < 256; i++) words[i] = 8'($urandom);
    out_ready = 1'b1;
    @(posedge clk); #1;
    while (recv < 256 && cyc < 400) begin
      if (sent < 256) begin
        in_valid = 1'b1; rrdata = words[sent]; rrsel = 3'(sent % 8);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) stalls++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got %h want no output", rrout);
        end else begin
          exp = q.pop_front();
          if (rrout !== exp) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", recv, rrout, exp); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_rot(rrdata, rrsel));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (recv != 256) begin n_fail++; $display("FAIL stream_count: got %0d want 256", recv); end
    n_cmp++;
    if (last - first != 255) begin n_fail++; $display("FAIL stream_rate: got span %0d want 255", last - first); end
    n_cmp++;
    if (stalls != 0) begin n_fail++; $display("FAIL stream_in_ready: got %0d stalls want 0", stalls); end
  endtask

  task automatic test_backpressure();
    logic [7:0] wd   [4] = '{8'h11, 8'h96, 8'h3C, 8'hA5};
    logic [2:0] ws   [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [7:0] bexp [4] = '{8'h88, 8'hA5, 8'hE1, 8'h4B};
    logic [7:0] hold = 8'h00;
    logic       last_rdy = 1'b1;
    int acc = 0, recv = 0, unstable = 0, have = 0, extra = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      if (acc < 4) begin rrdata = wd[acc]; rrsel = ws[acc]; end
      #1;
      if (out_valid === 1'b1) begin
        if (have == 0) begin hold = rrout; have = 1; end
        else if (rrout !== hold) unstable++;
      end else if (have != 0) begin
        unstable++;
      end
      last_rdy = in_ready;
      if (in_ready && acc < 4) acc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (acc != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", acc); end
    n_cmp++;
    if (last_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", last_rdy); end
    n_cmp++;
    if (hold !== 8'h88) begin n_fail++; $display("FAIL bp_head: got %h want 88", hold); end
    n_cmp++;
    if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (acc < 4);
      if (acc < 4) begin rrdata = wd[acc]; rrsel = ws[acc]; end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (recv >= 4) begin
          n_fail++; extra++; $display("FAIL bp_extra: got %h want no output", rrout);
        end else if (rrout !== bexp[recv]) begin
          n_fail++; $display("FAIL bp_drain[%0d]: got %h want %h", recv, rrout, bexp[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (recv != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", recv); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp;
    logic [7:0] prev_out = 8'h00;
    bit offering = 0, prev_stall = 0;
    int sent = 0, recv = 0, cyc = 0;
    @(posedge clk); #1;
    while (recv < 1000 && cyc < 20000) begin
      if (!offering && sent < 1000 && $urandom_range(0, 1) == 1) begin
        offering = 1; rrdata = 8'($urandom); rrsel = 3'($urandom_range(0, 7));
      end
      in_valid  = offering;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || rrout !== prev_out) begin
          n_fail++; $display("FAIL rand_stall: got %b/%h want 1/%h", out_valid, rrout, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %h want no output", rrout);
        end else begin
          exp = q.pop_front();
          if (rrout !== exp) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", recv, rrout, exp); end
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = rrout;
      if (in_valid && in_ready) begin
        q.push_back(ref_rot(rrdata, rrsel));
        sent++; offering = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (recv != 1000) begin n_fail++; $display("FAIL rand_count: got %0d want 1000", recv); end
    n_cmp++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; rrdata = 8'(8'hC3 + i); rrsel = 3'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_full: got %b want 1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_flush: got %b want 0", out_valid); end
    rst_n = 1'b1;
    test_single(8'h0F, 3'd4, 1'b0, 8'hF0, "post_rst");
  endtask

  initial begin
    test_reset();
    test_single(8'h81, 3'd1, 1'b0, 8'hC0, "rot1");
    test_single(8'h5A, 3'd0, 1'b0, 8'h5A, "rot0");
    test_single(8'h01, 3'd7, 1'b0, 8'h02, "rot7");
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef RROT_SHIFT_MODE_EN
    test_single(8'h81, 3'd3, 1'b1, 8'h10, "shift3");
    test_single(8'h81, 3'd3, 1'b0, 8'h30, "rot3");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
